// File: rtl/sid_pot_pkg.sv
// Shared SID core types plus the paddle (POT) sampling constants.
// Phase, register-width and pad-level POT types live here so every SID block agrees on them.
package sid;

  typedef logic [7:0] reg8_t;
  typedef logic [8:0] reg9_t;

  // One-hot bus phase; a tick is the clk cycle that carries PHI2.
  localparam int PHI1 = 0;
  localparam int PHI2 = 1;
  typedef logic [1:0] phase_t;
  localparam phase_t PHASE_PHI2 = phase_t'(1 << PHI2);

  localparam int POT_PERIOD    = 512;
  localparam int POT_DISCHARGE = 256;

  typedef logic [1:0] pot_axis_t;

  typedef struct packed {
    pot_axis_t charged;
  } pot_i_t;

  typedef struct packed {
    logic discharge;
  } pot_o_t;

  typedef struct packed {
    reg8_t [1:0] xy;
  } pot_reg_t;

  localparam reg8_t POT_MAX        = 8'hFF;
  localparam reg9_t POT_LAST       = reg9_t'(POT_PERIOD - 1);
  localparam reg9_t POT_SENSE_LAST = reg9_t'(POT_DISCHARGE - 1);
  localparam reg9_t POT_SENSE_0    = reg9_t'(POT_DISCHARGE);

  typedef enum logic {
    POT_PH_DISCHARGE = 1'b0,
    POT_PH_SENSE     = 1'b1
  } pot_phase_e;

  function automatic logic pot_in_sense(reg9_t cnt);
    return cnt >= POT_SENSE_0;
  endfunction

endpackage

// File: rtl/sid_pot_if.sv
// Pad/register side bundle of the POT sequencer: bus phase and comparators in, discharge and result bytes out.
interface sid_pot_if;
  import sid::*;

  phase_t   phase;
  pot_i_t   pot_i;
  pot_o_t   pot_o;
  pot_reg_t pot_reg;

  modport master (
    output phase,
    output pot_i,
    input  pot_o,
    input  pot_reg
  );

  modport slave (
    input  phase,
    input  pot_i,
    output pot_o,
    output pot_reg
  );

endinterface

// File: rtl/sid_pot_axis.sv
// One paddle axis: counts sense ticks until the comparator first reports charged, saturating at 255.
// The count is published to the read-only byte on the last tick of the period, then restarts from zero.
module sid_pot_axis
  import sid::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_tick,
  input  logic  i_sense,
  input  logic  i_publish,
  input  logic  i_chg,
  output reg8_t o_pot
);

  reg8_t r_pos;
  reg8_t r_pot;
  logic  r_done;
  logic  w_adv;
  reg8_t w_pos_nxt;

  // Once done is set, later comparator drops cannot restart the count.
  assign w_adv     = !r_done && !i_chg && (r_pos != POT_MAX);
  assign w_pos_nxt = w_adv ? r_pos + 8'd1 : r_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos  <= '0;
      r_done <= 1'b0;
      r_pot  <= '0;
    end else if (i_tick) begin
      if (!i_sense || i_publish) begin
        r_pos  <= '0;
        r_done <= 1'b0;
      end else begin
        r_pos  <= w_pos_nxt;
        r_done <= r_done | i_chg;
      end
      if (i_publish) begin
        r_pot <= w_pos_nxt;
      end
    end
  end

  assign o_pot = r_pot;

endmodule

// File: rtl/sid_pot.sv
// POT X/Y sampling sequencer: 256 ticks discharging the pot caps, then 256 ticks timing their recharge.
// Owns the shared period counter, discharge control and comparator synchronizer; one sid_pot_axis per axis.
module sid_pot
  import sid::*;
(
  input  logic      clk,
  input  logic      rst,
  sid_pot_if.slave  bus
);

  reg9_t       r_cnt;
  pot_axis_t   r_sync1;
  pot_axis_t   r_sync2;
  pot_phase_e  r_state;
  pot_phase_e  w_state_nxt;
  reg9_t       w_cnt_nxt;
  logic        w_tick;
  logic        w_sense;
  logic        w_publish;
  reg8_t [1:0] w_xy;

  assign w_tick    = (bus.phase == PHASE_PHI2);
  assign w_sense   = pot_in_sense(r_cnt);
  assign w_publish = (r_cnt == POT_LAST);

  // Comparators are asynchronous to clk; the synchronizer runs on every clk, tick or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.pot_i.charged;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    if (w_tick) begin
      w_cnt_nxt = r_cnt + 9'd1;
      if (r_cnt == POT_SENSE_LAST) begin
        w_state_nxt = POT_PH_SENSE;
      end else if (r_cnt == POT_LAST) begin
        w_state_nxt = POT_PH_DISCHARGE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= POT_PH_DISCHARGE;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  // The phase register is the discharge flop itself, so the pin only moves on period-boundary ticks.
  assign bus.pot_o.discharge = (r_state == POT_PH_DISCHARGE);

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    sid_pot_axis u_axis (
      .clk       (clk),
      .rst       (rst),
      .i_tick    (w_tick),
      .i_sense   (w_sense),
      .i_publish (w_publish),
      .i_chg     (r_sync2[gi]),
      .o_pot     (w_xy[gi])
    );
  end

  assign bus.pot_reg.xy = w_xy;

endmodule

// File: doc/sid_pot.md
# sid_pot

Paddle (POT X/Y) sampling sequencer for the SID core. It alternately discharges the external POT capacitors and times their recharge, once per 512 φ2 cycles. Each completed measurement is published as the 8-bit POTX/POTY read-only register bytes consumed by the register read mux. It sits between the pad-level `pot_i_t`/`pot_o_t` signals and `misc_reg_t.pot`.

## Interface
- No parameters. Period and phase lengths are package constants.
- `clk  in  1  system clock`
- `rst  in  1  synchronous reset, active-high`
- `phase  in  sid::phase_t  one-hot bus phase; the tick is the clk cycle with phase[PHI2]=1`
- `pot_i  in  sid::pot_i_t  charged[1:0]: comparator outputs (bit 0 = X, bit 1 = Y), asynchronous to clk`
- `pot_o  out  sid::pot_o_t  discharge: 1 = drive both POT pins low`
- `pot_reg  out  sid::pot_reg_t  xy[0] = POTX, xy[1] = POTY, last completed measurement`

## Operation
- Period counter `cnt` (9 bits) advances by 1 on every tick and wraps 511→0.
- **Discharge phase**, cnt 0..255:
  - discharge=1.
  - Position counters are held at 0.
  - The done flags are held clear.
- **Sense phase**, cnt 256..511:
  - discharge=0.
  - Per axis i, on each tick: if !done[i] && !chg_s[i] && pos[i]!=255, then pos[i]++.
  - If chg_s[i]=1, then done[i] is set and pos[i] is frozen for the rest of the period. Comparator noise after first charge is ignored.
- **Saturation:** the sense phase has 256 ticks, so a never-charging pot saturates at 255. There is no wrap to 0.
- **Publish:** on the tick with cnt==511:
  - pot_reg.xy[i] ← the pos[i] value including that tick's update.
  - pos ← 0.
  - done ← 0.
- **Synchronizer:** chg_s is pot_i.charged passed through a 2-flop synchronizer clocked by clk. Sampling uses chg_s as it stands at the tick.
- **Independence:** the X and Y axes are fully independent. Any combination of charged states is legal.
- **Reset values:** cnt=0, pos=0, done=0, synchronizer flops=0, pot_o.discharge=1, pot_reg.xy=0x00/0x00.
- **Reset mid-period:** the in-flight measurement is discarded and pot_reg returns to 0. The sequence restarts at the discharge phase.
- **No tick:** when phase[PHI2]=0, all state holds. The synchronizer keeps running.

## Timing
- pot_o.discharge is registered and is a function of cnt.
  - It falls on the clk edge of the tick where cnt goes 255→256.
  - It rises on the edge of the tick where cnt goes 511→0.
- pot_reg updates on the clk edge of the cnt==511 tick. It is stable for the following 512 ticks.
- First valid measurement after reset: 512 ticks after the first tick.
- Comparator latency: 2 clk, plus wait until the next tick.
  - Required: tick spacing ≥3 clk. This holds at the system clock to φ2 ratio.
  - A charge edge arriving within 2 clk before a tick is counted on the following tick (±1 LSB).
- Charged seen at the first sense tick (cnt==256) gives value 0.

## Structure
- Add to package `sid`:
  - `POT_PERIOD = 512`
  - `POT_DISCHARGE = 256`
  - `typedef logic [1:0] pot_axis_t`
- Reuse the existing types: `reg9_t` for cnt, `reg8_t` for pos, and `pot_i_t`/`pot_o_t`/`pot_reg_t`.
- One sub-module, `sid_pot_axis`: one per axis, containing pos, done, the saturation logic, and the publish register.
- cnt, the discharge output and the synchronizer live in the top module and are shared by both axes.

## Test plan
- **Reset:** assert rst mid-sense-phase with pos≈100. Required: pot_reg=0x00/0x00 and discharge=1 on the next clk; the first publish comes after 512 ticks.
- **Nominal:** X charges at sense tick 100 (cnt==356), Y charges at tick 37. Required: after the cnt==511 tick, POTX=0x64 and POTY=0x25.
- **Boundaries:**
  - charged held high throughout → 0x00.
  - charged always low → 0xFF with no wrap.
  - charged asserted exactly at the cnt==511 tick → 0xFF.
- **Glitch immunity:** X charges at tick 50, drops at tick 60, recharges at tick 80. Required: POTX=0x32.
- **Discharge timing:** measure discharge across several periods. Required: high for exactly 256 ticks, low for exactly 256 ticks, transitions on the ticks where cnt goes 255→256 and 511→0.
- **Tick gating:** stretch the tick spacing randomly (3..40 clk) and use an async charged edge. Required: the result matches the reference count ±1, and no state changes on clk cycles without a tick.
